pc_update: RTL and testbench
============================

# pc_update

Next-PC selection and program-counter register for the Y86-64 sequential (SEQ) processor. It sits at the end of the SEQ datapath, after fetch, execute and memory. From the current instruction's opcode, condition flag and the fetch/execute/memory results, it computes the next PC combinationally and commits it to the architectural PC on each clock edge. It also stops PC advance once a halt or invalid instruction is committed.

## Interface
Parameters:
- `WIDTH`, 64: address/data width of valP, valC, valM, PC.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock. One clock; PC state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `opcode`  in  8  instruction byte. [7:4] = icode, [3:0] = ifun.
- `Cnd`  in  1  condition result from execute; used only for jXX.
- `valP`  in  WIDTH  address of the sequentially next instruction.
- `valC`  in  WIDTH  instruction constant (jump/call target).
- `valM`  in  WIDTH  value read from memory (return address for ret).
- `finalval_PC`  out  WIDTH  combinational next-PC.
- `PC`  out  WIDTH  registered architectural PC.
- `halted`  out  1  sticky flag; set once halt or an invalid icode is committed.

## Operation
finalval_PC is purely combinational and depends only on opcode, Cnd, valP, valC and valM. It does not depend on clk, rst or halted. Selection by icode:
- 0x7 (jXX): Cnd=1 → valC; Cnd=0 → valP. ifun is ignored. Upstream drives Cnd=1 for unconditional jmp.
- 0x8 (call): valC, regardless of Cnd.
- 0x9 (ret): valM.
- 0x0–0x6, 0xA, 0xB (halt, nop, cmovXX/rrmovq, irmovq, rmmovq, mrmovq, OPq, pushq, popq): valP. Cnd is ignored.
- 0xC–0xF (invalid): valP.

Other rules:
- All values pass through unmodified. No arithmetic and no width conversion.
- Registered PC on the rising edge of clk:
  - If rst: PC ← RESET_PC, halted ← 0.
  - Else if halted: PC holds, halted stays 1.
  - Else if icode = 0x0 or icode ≥ 0xC: PC holds, halted ← 1.
  - Else: PC ← finalval_PC.
- Only rst clears halted.
- Reset takes priority over every other condition in the same cycle.
- Inputs that change between clock edges affect only finalval_PC. PC samples them at the edge.

## Timing
- finalval_PC: zero-cycle combinational path from inputs.
- PC: one-cycle latency. The value of finalval_PC at rising edge N appears on PC after edge N.
- Reset values: PC = RESET_PC (0), halted = 0. finalval_PC is not reset; it always reflects its current inputs.
- Reset asserted mid-run: PC returns to RESET_PC at the next edge and halted clears. Any pending next-PC is discarded.
- Halt committed at edge N: PC keeps the halt instruction's address from edge N onward. finalval_PC still reports valP.
- No handshake. One instruction commits per clock.

## Structure
- Shared SEQ package holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=0xA, IPOPQ=0xB.
  - WIDTH default.
- One natural sub-module: `pc_next_sel`, the combinational mux producing finalval_PC. The top instantiates it, adds the PC register and halted logic, and exports finalval_PC.

## Test plan
- jXX not taken: opcode=0x74, valP=10000, valC=90, valM=20, Cnd=0 → finalval_PC=10000 within the same cycle; PC=10000 after the next edge.
- jXX taken: opcode=0x74, valP=100010, valC=90, valM=20, Cnd=1 → finalval_PC=90. Repeat with Cnd=0, valP=2000, valC=100 → finalval_PC=2000.
- Non-control op and call: opcode=0x20, valP=890, valC=91, valM=30, Cnd=0 → finalval_PC=890. opcode=0x80, valP=10, valC=500, Cnd=0 → finalval_PC=500.
- ret: opcode=0x90, valP=910, valC=95, valM=25, Cnd=1 → finalval_PC=25; PC=25 after the edge.
- Halt and invalid:
  - Sequence nop (valP=8) then halt (opcode=0x00, valP=9) → PC=8, then holds at 8; halted=1.
  - Further edges with opcode=0x10 keep PC=8.
  - Repeat from reset using opcode=0xC0: same behaviour.
- Reset: assert rst for one edge while PC=8 and halted=1 → PC=0, halted=0. Deassert, apply opcode=0x10, valP=2 → PC=2 after the next edge. rst asserted together with a taken jump → PC=0.

Source files
------------

// File: rtl/pc_update_pkg.sv
// Shared definitions for the Y86-64 SEQ datapath.
// Holds the icode values, the default datapath width and a helper that
// identifies instructions which stop PC advance when committed.
package pc_update_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // Upper nibble of the instruction byte.
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // halt and every icode above popq (0xC..0xF) freeze the PC.
  function automatic logic is_stop_icode(input logic [3:0] icode);
    return (icode == IHALT) || (icode > IPOPQ);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC multiplexer.
// Ports:
//   icode        in   4      instruction class (opcode[7:4])
//   Cnd          in   1      branch condition, only meaningful for jXX
//   valP         in   WIDTH  fall-through address
//   valC         in   WIDTH  jump/call target
//   valM         in   WIDTH  return address popped by ret
//   finalval_PC  out  WIDTH  selected next PC
module pc_next_sel
  import pc_update_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       icode,
  input  logic             Cnd,
  input  logic [WIDTH-1:0] valP,
  input  logic [WIDTH-1:0] valC,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] finalval_PC
);

  always_comb begin
    // NOTE: default first and blocking '=' in combinational logic keeps every
    // path assigned, so no latch is inferred.
    finalval_PC = valP;
    unique case (icode)
      IJXX:    finalval_PC = Cnd ? valC : valP;
      ICALL:   finalval_PC = valC;
      IRET:    finalval_PC = valM;
      default: finalval_PC = valP;  // straight-line, halt and invalid codes
    endcase
  end

endmodule

// File: rtl/pc_update.sv
// Next-PC selection and architectural PC register for the SEQ processor.
// Ports:
//   clk          in   1      clock, PC updates on rising edge
//   rst          in   1      synchronous active-high reset
//   opcode       in   8      instruction byte, [7:4] icode, [3:0] ifun
//   Cnd          in   1      condition result from execute (jXX only)
//   valP         in   WIDTH  sequential next address
//   valC         in   WIDTH  instruction constant
//   valM         in   WIDTH  memory read value
//   finalval_PC  out  WIDTH  combinational next PC
//   PC           out  WIDTH  registered architectural PC
//   halted       out  1      sticky, set when halt/invalid commits
module pc_update
  import pc_update_pkg::*;
#(
  parameter int              WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opcode,
  input  logic             Cnd,
  input  logic [WIDTH-1:0] valP,
  input  logic [WIDTH-1:0] valC,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] finalval_PC,
  output logic [WIDTH-1:0] PC,
  output logic             halted
);

  logic [3:0] icode;
  logic       unused_ifun;

  assign icode       = opcode[7:4];
  // ifun only distinguishes jXX conditions, which execute has already
  // folded into Cnd.
  assign unused_ifun = ^opcode[3:0];

  pc_next_sel #(.WIDTH(WIDTH)) u_pc_next_sel (
    .icode       (icode),
    .Cnd         (Cnd),
    .valP        (valP),
    .valC        (valC),
    .valM        (valM),
    .finalval_PC (finalval_PC)
  );

  // Reset dominates; once halted, nothing but reset moves the PC again.
  // A committing halt/invalid leaves PC on its own address.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking '<=' for state so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      PC     <= RESET_PC;
      halted <= 1'b0;
    end else if (!halted) begin
      if (is_stop_icode(icode)) begin
        halted <= 1'b1;
      end else begin
        PC <= finalval_PC;
      end
    end
  end

endmodule

// File: tb/tb_pc_update.sv
// Directed self-checking bench for pc_update.
module tb_pc_update;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   opcode;
  logic         Cnd;
  logic [W-1:0] valP, valC, valM;
  logic [W-1:0] finalval_PC, PC;
  logic         halted;

  int checks = 0;
  int errors = 0;

  pc_update #(.WIDTH(W), .RESET_PC('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .Cnd         (Cnd),
    .valP        (valP),
    .valC        (valC),
    .valM        (valM),
    .finalval_PC (finalval_PC),
    .PC          (PC),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after a rising edge, well away from the next one.
  task automatic drive(input logic [7:0] op, input logic c,
                       input logic [W-1:0] p, input logic [W-1:0] k, input logic [W-1:0] m);
    opcode = op;
    Cnd    = c;
    valP   = p;
    valC   = k;
    valM   = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h10, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
    check("reset_pc", PC, 64'd0);
    check("reset_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;

    // jXX not taken
    drive(8'h74, 1'b0, 64'd10000, 64'd90, 64'd20);
    check("jxx_nt_comb", finalval_PC, 64'd10000);
    tick();
    check("jxx_nt_pc", PC, 64'd10000);

    // jXX taken
    drive(8'h74, 1'b1, 64'd100010, 64'd90, 64'd20);
    check("jxx_t_comb", finalval_PC, 64'd90);
    tick();
    check("jxx_t_pc", PC, 64'd90);

    drive(8'h74, 1'b0, 64'd2000, 64'd100, 64'd20);
    check("jxx_nt2_comb", finalval_PC, 64'd2000);
    tick();
    check("jxx_nt2_pc", PC, 64'd2000);

    // rrmovq, Cnd ignored in both polarities
    drive(8'h20, 1'b0, 64'd890, 64'd91, 64'd30);
    check("rrmov_comb", finalval_PC, 64'd890);
    drive(8'h20, 1'b1, 64'd890, 64'd91, 64'd30);
    check("rrmov_cnd1_comb", finalval_PC, 64'd890);
    tick();
    check("rrmov_pc", PC, 64'd890);

    // call
    drive(8'h80, 1'b0, 64'd10, 64'd500, 64'd30);
    check("call_comb", finalval_PC, 64'd500);
    tick();
    check("call_pc", PC, 64'd500);

    // ret
    drive(8'h90, 1'b1, 64'd910, 64'd95, 64'd25);
    check("ret_comb", finalval_PC, 64'd25);
    tick();
    check("ret_pc", PC, 64'd25);

    // popq at the top of the straight-line range
    drive(8'hB0, 1'b1, 64'd33, 64'd44, 64'd55);
    check("popq_comb", finalval_PC, 64'd33);

    // nop then halt
    drive(8'h10, 1'b0, 64'd8, 64'd1, 64'd2);
    tick();
    check("nop_pc", PC, 64'd8);
    check("nop_halted", {63'd0, halted}, 64'd0);
    drive(8'h00, 1'b0, 64'd9, 64'd1, 64'd2);
    check("halt_comb", finalval_PC, 64'd9);
    tick();
    check("halt_pc", PC, 64'd8);
    check("halt_halted", {63'd0, halted}, 64'd1);
    drive(8'h10, 1'b0, 64'd20, 64'd1, 64'd2);
    check("halted_comb", finalval_PC, 64'd20);
    tick();
    check("halted_pc1", PC, 64'd8);
    tick();
    check("halted_pc2", PC, 64'd8);
    check("halted_sticky", {63'd0, halted}, 64'd1);

    // reset while halted
    rst = 1'b1;
    tick();
    check("rst_halt_pc", PC, 64'd0);
    check("rst_halt_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;
    drive(8'h10, 1'b0, 64'd2, 64'd0, 64'd0);
    tick();
    check("post_rst_pc", PC, 64'd2);

    // invalid icode behaves like halt
    drive(8'h10, 1'b0, 64'd8, 64'd0, 64'd0);
    tick();
    check("nop2_pc", PC, 64'd8);
    drive(8'hC0, 1'b1, 64'd9, 64'd77, 64'd66);
    check("inv_comb", finalval_PC, 64'd9);
    tick();
    check("inv_pc", PC, 64'd8);
    check("inv_halted", {63'd0, halted}, 64'd1);
    drive(8'h10, 1'b0, 64'd30, 64'd0, 64'd0);
    tick();
    check("inv_hold_pc", PC, 64'd8);
    drive(8'hF5, 1'b1, 64'd123, 64'd456, 64'd789);
    check("inv_f_comb", finalval_PC, 64'd123);

    // reset coincident with a taken jump
    rst = 1'b1;
    drive(8'h74, 1'b1, 64'd100, 64'd90, 64'd20);
    check("rst_jmp_comb", finalval_PC, 64'd90);
    tick();
    check("rst_jmp_pc", PC, 64'd0);
    check("rst_jmp_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_jmp_pc", PC, 64'd90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
